// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO (UART RX/TX byte buffer).
// Ports:
//   clk_i    - clock, all state updates on the rising edge
//   rst_ni   - asynchronous active-low reset, clears pointers, count and storage
//   wdata_i  - word to enqueue
//   we_i     - write enable, ignored while full
//   re_i     - read enable (pop), ignored while empty
//   rdata_o  - head-of-queue word, combinational, no read latency
//   full_o   - DEPTH entries stored
//   empty_o  - no entries stored
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             we_i,
    input  logic             re_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_acc;
    logic             rd_acc;

    // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1 only.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
    endfunction

    // Flags and head word come straight from the current state.
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);
    assign rdata_o = mem_q[rd_ptr_q];

    // Acceptance uses pre-edge flags: write-on-full and read-on-empty are dropped.
    assign wr_acc = we_i & ~full_o;
    assign rd_acc = re_i & ~empty_o;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_acc) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so rdata_o is 0 rather than X afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_acc) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: drives a DEPTH=32 and a DEPTH=5 sync_fifo with the same
// stimulus; each has its own reference queue, plus a vector table for the
// deep instance and hand-written corner sequences.
module tb_sync_fifo;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 32;
    localparam int unsigned D5 = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] wdata;
    logic         we;
    logic         re;

    logic [W-1:0] rd32, rd5;
    logic         full32, empty32, full5, empty5;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] sb32[$];
    logic [W-1:0] sb5[$];

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(W), .DEPTH(D)) u_dut32 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .wdata_i(wdata),
        .we_i   (we),
        .re_i   (re),
        .rdata_o(rd32),
        .full_o (full32),
        .empty_o(empty32)
    );

    sync_fifo #(.WIDTH(W), .DEPTH(D5)) u_dut5 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .wdata_i(wdata),
        .we_i   (we),
        .re_i   (re),
        .rdata_o(rd5),
        .full_o (full5),
        .empty_o(empty5)
    );

    typedef struct {
        logic         we;
        logic         re;
        logic [W-1:0] wd;
        logic         chk_rd;
        logic [W-1:0] rd;
        logic         empty;
        logic         full;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flags and head of both instances against their reference queues.
    task automatic check_state();
        chk("empty32", 32'(empty32), 32'(sb32.size() == 0));
        chk("full32",  32'(full32),  32'(sb32.size() == D));
        chk("empty5",  32'(empty5),  32'(sb5.size() == 0));
        chk("full5",   32'(full5),   32'(sb5.size() == D5));
        if (sb32.size() > 0) chk("head32", 32'(rd32), 32'(sb32[0]));
        if (sb5.size() > 0)  chk("head5",  32'(rd5),  32'(sb5[0]));
    endtask

    // One clock of stimulus; call with clk low. Pops are compared at the
    // moment the read is issued, then flags/head are checked after the edge.
    task automatic op(input logic w, input logic r, input logic [W-1:0] d);
        bit r32, w32, r5, w5;
        we    = w;
        re    = r;
        wdata = d;
        r32 = r && (sb32.size() > 0);
        w32 = w && (sb32.size() < D);
        r5  = r && (sb5.size() > 0);
        w5  = w && (sb5.size() < D5);
        #1;
        if (r32) chk("pop32", 32'(rd32), 32'(sb32[0]));
        if (r5)  chk("pop5",  32'(rd5),  32'(sb5[0]));
        @(posedge clk);
        if (r32) void'(sb32.pop_front());
        if (w32) sb32.push_back(d);
        if (r5)  void'(sb5.pop_front());
        if (w5)  sb5.push_back(d);
        @(negedge clk);
        we = 1'b0;
        re = 1'b0;
        check_state();
    endtask

    task automatic do_reset_check(input string tag);
        chk({tag, "_empty32"}, 32'(empty32), 32'd1);
        chk({tag, "_full32"},  32'(full32),  32'd0);
        chk({tag, "_rd32"},    32'(rd32),    32'd0);
        chk({tag, "_empty5"},  32'(empty5),  32'd1);
        chk({tag, "_full5"},   32'(full5),   32'd0);
        chk({tag, "_rd5"},     32'(rd5),     32'd0);
    endtask

    initial begin
        int written;
        int cycles;

        tbl[0]  = '{we:1'b1, re:1'b0, wd:8'h41, chk_rd:1'b1, rd:8'h41, empty:1'b0, full:1'b0};
        tbl[1]  = '{we:1'b1, re:1'b0, wd:8'h42, chk_rd:1'b1, rd:8'h41, empty:1'b0, full:1'b0};
        tbl[2]  = '{we:1'b1, re:1'b0, wd:8'h43, chk_rd:1'b1, rd:8'h41, empty:1'b0, full:1'b0};
        tbl[3]  = '{we:1'b0, re:1'b1, wd:8'h00, chk_rd:1'b1, rd:8'h42, empty:1'b0, full:1'b0};
        tbl[4]  = '{we:1'b0, re:1'b1, wd:8'h00, chk_rd:1'b1, rd:8'h43, empty:1'b0, full:1'b0};
        tbl[5]  = '{we:1'b0, re:1'b1, wd:8'h00, chk_rd:1'b0, rd:8'h00, empty:1'b1, full:1'b0};
        tbl[6]  = '{we:1'b0, re:1'b1, wd:8'h00, chk_rd:1'b0, rd:8'h00, empty:1'b1, full:1'b0};
        tbl[7]  = '{we:1'b1, re:1'b0, wd:8'h5A, chk_rd:1'b1, rd:8'h5A, empty:1'b0, full:1'b0};
        tbl[8]  = '{we:1'b0, re:1'b1, wd:8'h00, chk_rd:1'b0, rd:8'h00, empty:1'b1, full:1'b0};
        tbl[9]  = '{we:1'b1, re:1'b0, wd:8'h10, chk_rd:1'b1, rd:8'h10, empty:1'b0, full:1'b0};
        tbl[10] = '{we:1'b1, re:1'b1, wd:8'h20, chk_rd:1'b1, rd:8'h20, empty:1'b0, full:1'b0};
        tbl[11] = '{we:1'b0, re:1'b1, wd:8'h00, chk_rd:1'b0, rd:8'h00, empty:1'b1, full:1'b0};
        tbl[12] = '{we:1'b1, re:1'b1, wd:8'h77, chk_rd:1'b1, rd:8'h77, empty:1'b0, full:1'b0};
        tbl[13] = '{we:1'b0, re:1'b1, wd:8'h00, chk_rd:1'b0, rd:8'h00, empty:1'b1, full:1'b0};

        rst_n = 1'b0;
        we    = 1'b0;
        re    = 1'b0;
        wdata = '0;
        #12;
        do_reset_check("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Ordering, underflow and simultaneous read/write vectors.
        foreach (tbl[i]) begin
            op(tbl[i].we, tbl[i].re, tbl[i].wd);
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rd", i), 32'(rd32), 32'(tbl[i].rd));
            chk($sformatf("vec%0d_empty", i), 32'(empty32), 32'(tbl[i].empty));
            chk($sformatf("vec%0d_full", i),  32'(full32),  32'(tbl[i].full));
        end

        // Fill, overflow write, full drain.
        for (int i = 0; i < int'(D); i++) op(1'b1, 1'b0, 8'(i));
        chk("fill_full", 32'(full32), 32'd1);
        op(1'b1, 1'b0, 8'hFF);
        chk("ovf_full", 32'(full32), 32'd1);
        chk("ovf_head", 32'(rd32), 32'h00);
        for (int i = 0; i < int'(D); i++) begin
            chk($sformatf("drain%0d", i), 32'(rd32), 32'(i));
            op(1'b0, 1'b1, 8'h00);
        end
        chk("drain_empty", 32'(empty32), 32'd1);

        // Simultaneous read/write on a full FIFO: read wins, write dropped.
        for (int i = 0; i < int'(D); i++) op(1'b1, 1'b0, 8'(8'h80 + i));
        op(1'b1, 1'b1, 8'hEE);
        chk("rw_full_full", 32'(full32), 32'd0);
        chk("rw_full_head", 32'(rd32), 32'h81);
        while (sb32.size() > 0 || sb5.size() > 0) op(1'b0, 1'b1, 8'h00);
        chk("rw_full_empty", 32'(empty32), 32'd1);

        // Wrap-around: random read/write bursts, 20 words through both FIFOs.
        written = 0;
        cycles  = 0;
        while ((written < 20 || sb5.size() > 0 || sb32.size() > 0) && cycles < 400) begin
            logic w, r;
            w = (written < 20) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) == 0) || (written >= 20);
            if (w && sb5.size() < D5) written++;
            op(w, r, 8'(8'hA0 + written));
            cycles++;
        end
        chk("wrap_done", 32'(cycles < 400), 32'd1);

        // Asynchronous reset mid-cycle with data stored.
        op(1'b1, 1'b0, 8'h11);
        op(1'b1, 1'b0, 8'h22);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        do_reset_check("arst");
        sb32.delete();
        sb5.delete();
        @(negedge clk);
        rst_n = 1'b1;
        op(1'b1, 1'b0, 8'h5A);
        chk("post_rst_rd", 32'(rd32), 32'h5A);
        chk("post_rst_rd5", 32'(rd5), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
